// File: rtl/calculator_pkg.sv
// Shared types for the calculator sequencing controller: FSM state encoding
// (doubles as the LED state code) and the ALU opcode set.
package calculator_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_ENTER_OP = 3'd2,
    ST_BUSY     = 3'd3,
    ST_RESULT   = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

endpackage

// File: rtl/calculator_ctrl_edge_detect.sv
// Rising-edge detector for a debounced, synchronized button level.
// A held button yields exactly one rise pulse.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/calculator_ctrl.sv
// Calculator sequencing FSM: operand/opcode entry, ALU launch with timeout, result/error hold.
// Optional build macro CALC_CHAIN_EN: Enter in RESULT loads the result into operand A.
module calculator_ctrl
  import calculator_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button_clr,
  input  logic             button_ent,
  input  logic [WIDTH-1:0] switches,
  input  logic [1:0]       op_sel,
  output logic             alu_start,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] display_value,
  output logic [2:0]       state_code,
  output logic             error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] result_q;
  logic             clr_rise, ent_rise, clr_ev, ent_ev;
  logic             load_a, load_b, load_op, load_res, clear_regs, start_d, chain_a;

  edge_detect u_clr_edge (.clk(clk), .reset(reset), .level(button_clr), .rise(clr_rise));
  edge_detect u_ent_edge (.clk(clk), .reset(reset), .level(button_ent), .rise(ent_rise));

  // Clear has priority; a simultaneous Enter is dropped.
  assign clr_ev = clr_rise;
  assign ent_ev = ent_rise & ~clr_rise;

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    clear_regs = 1'b0;
    start_d    = 1'b0;
    chain_a    = 1'b0;
    if (clr_ev) begin
      state_d    = ST_ENTER_A;
      clear_regs = 1'b1;
      cnt_d      = '0;
    end else begin
      case (state)
        ST_ENTER_A: if (ent_ev) begin
          load_a  = 1'b1;
          state_d = ST_ENTER_B;
        end
        ST_ENTER_B: if (ent_ev) begin
          load_b  = 1'b1;
          state_d = ST_ENTER_OP;
        end
        ST_ENTER_OP: if (ent_ev) begin
          load_op = 1'b1;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
        ST_BUSY: begin
          // A done arriving on the timeout cycle still counts as completion.
          if (alu_done) begin
            if (alu_err) state_d = ST_ERROR;
            else begin
              load_res = 1'b1;
              state_d  = ST_RESULT;
            end
          end else if (cnt == CNT_LAST) begin
            state_d = ST_ERROR;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
        ST_RESULT: if (ent_ev) begin
`ifdef CALC_CHAIN_EN
          chain_a = 1'b1;
          state_d = ST_ENTER_B;
`else
          state_d = ST_ENTER_A;
`endif
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_ENTER_A;
      cnt       <= '0;
      alu_start <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= OP_ADD;
      result_q  <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      alu_start <= start_d;
      if (load_res) result_q <= alu_result;
      if (clear_regs) begin
        alu_a  <= '0;
        alu_b  <= '0;
        alu_op <= OP_ADD;
      end else begin
        if (load_a)  alu_a  <= switches;
        if (chain_a) alu_a  <= result_q;
        if (load_b)  alu_b  <= switches;
        if (load_op) alu_op <= op_sel;
      end
    end
  end

  always_comb begin
    case (state)
      ST_ENTER_A, ST_ENTER_B: display_value = switches;
      ST_ENTER_OP:            display_value = {{(WIDTH-2){1'b0}}, op_sel};
      ST_ERROR:               display_value = '1;
      default:                display_value = result_q;
    endcase
  end

  assign state_code = state;
  assign error      = (state == ST_ERROR);

endmodule

// File: tb/tb_calculator_ctrl.sv
// Directed bench for calculator_ctrl: table-driven add sequence plus hand-written
// hold, divide-error, timeout, mid-BUSY clear and simultaneous-button sequences.
module tb_calculator_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         button_clr, button_ent;
  logic [W-1:0] switches;
  logic [1:0]   op_sel;
  logic         alu_start;
  logic [W-1:0] alu_a, alu_b;
  logic [1:0]   alu_op;
  logic         alu_done;
  logic [W-1:0] alu_result;
  logic         alu_err;
  logic [W-1:0] display_value;
  logic [2:0]   state_code;
  logic         error;

  int tests = 0;
  int fails = 0;

  calculator_ctrl #(.WIDTH(W), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .button_clr(button_clr), .button_ent(button_ent),
    .switches(switches), .op_sel(op_sel), .alu_start(alu_start), .alu_a(alu_a),
    .alu_b(alu_b), .alu_op(alu_op), .alu_done(alu_done), .alu_result(alu_result),
    .alu_err(alu_err), .display_value(display_value), .state_code(state_code),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       clr;
    logic       ent;
    logic [7:0] sw;
    logic [1:0] op;
    logic       done;
    logic [7:0] res;
    logic       err;
    logic [2:0] e_state;
    logic [7:0] e_disp;
    logic       e_start;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic [1:0] e_op;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic e, input logic [7:0] s, input logic [1:0] o,
                      input logic d, input logic [7:0] r, input logic er);
    @(negedge clk);
    button_clr = c; button_ent = e; switches = s; op_sel = o;
    alu_done = d; alu_result = r; alu_err = er;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [7:0] s);
    step(1'b0, 1'b0, s, 2'd0, 1'b0, 8'd0, 1'b0);
  endtask

  // Drives A=a, B=b, op=o through the entry states, ending in BUSY.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [1:0] o);
    step(1'b0, 1'b1, a, o, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, b, o, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, b, o, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, b, o, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b1, b, o, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    int n;
    int trans;
    int starts;
    logic [2:0] prev_st;

    //          clr ent sw     op  done res    err  st disp  start a      b     op
    vecs[0] = '{1'b0,1'b1,8'd5, 2'd0,1'b0,8'd0,1'b0, 3'd1,8'd5, 1'b0,8'd5,8'd0,2'd0};
    vecs[1] = '{1'b0,1'b0,8'd3, 2'd0,1'b0,8'd0,1'b0, 3'd1,8'd3, 1'b0,8'd5,8'd0,2'd0};
    vecs[2] = '{1'b0,1'b1,8'd3, 2'd0,1'b0,8'd0,1'b0, 3'd2,8'd0, 1'b0,8'd5,8'd3,2'd0};
    vecs[3] = '{1'b0,1'b0,8'd3, 2'd1,1'b0,8'd0,1'b0, 3'd2,8'd1, 1'b0,8'd5,8'd3,2'd0};
    vecs[4] = '{1'b0,1'b1,8'd3, 2'd0,1'b0,8'd0,1'b0, 3'd3,8'd0, 1'b1,8'd5,8'd3,2'd0};
    vecs[5] = '{1'b0,1'b0,8'd3, 2'd0,1'b0,8'd0,1'b0, 3'd3,8'd0, 1'b0,8'd5,8'd3,2'd0};
    vecs[6] = '{1'b0,1'b0,8'd3, 2'd0,1'b1,8'd8,1'b0, 3'd4,8'd8, 1'b0,8'd5,8'd3,2'd0};
    vecs[7] = '{1'b0,1'b0,8'd3, 2'd0,1'b0,8'd0,1'b0, 3'd4,8'd8, 1'b0,8'd5,8'd3,2'd0};
`ifdef CALC_CHAIN_EN
    vecs[8] = '{1'b0,1'b1,8'h11,2'd0,1'b0,8'd0,1'b0, 3'd1,8'h11,1'b0,8'd8,8'd3,2'd0};
    vecs[9] = '{1'b0,1'b0,8'h11,2'd0,1'b0,8'd0,1'b0, 3'd1,8'h11,1'b0,8'd8,8'd3,2'd0};
`else
    vecs[8] = '{1'b0,1'b1,8'h11,2'd0,1'b0,8'd0,1'b0, 3'd0,8'h11,1'b0,8'd5,8'd3,2'd0};
    vecs[9] = '{1'b0,1'b0,8'h11,2'd0,1'b0,8'd0,1'b0, 3'd0,8'h11,1'b0,8'd5,8'd3,2'd0};
`endif

    reset = 1'b1; button_clr = 1'b0; button_ent = 1'b0; switches = '0; op_sel = '0;
    alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(state_code), 32'd0);
    check("reset_a", 32'(alu_a), 32'd0);
    check("reset_b", 32'(alu_b), 32'd0);
    check("reset_op", 32'(alu_op), 32'd0);
    check("reset_start", 32'(alu_start), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_disp", 32'(display_value), 32'd0);
    reset = 1'b0;

    // Table: 5 + 3, stub done with 8 two cycles after start, then Enter in RESULT.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].clr, vecs[i].ent, vecs[i].sw, vecs[i].op, vecs[i].done, vecs[i].res, vecs[i].err);
      check($sformatf("v%0d_state", i), 32'(state_code), 32'(vecs[i].e_state));
      check($sformatf("v%0d_disp", i), 32'(display_value), 32'(vecs[i].e_disp));
      check($sformatf("v%0d_start", i), 32'(alu_start), 32'(vecs[i].e_start));
      check($sformatf("v%0d_a", i), 32'(alu_a), 32'(vecs[i].e_a));
      check($sformatf("v%0d_b", i), 32'(alu_b), 32'(vecs[i].e_b));
      check($sformatf("v%0d_op", i), 32'(alu_op), 32'(vecs[i].e_op));
    end

    // Back to ENTER_A with cleared operands.
    step(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0);
    check("clr_state", 32'(state_code), 32'd0);
    check("clr_a", 32'(alu_a), 32'd0);
    idle(8'd0);

    // Held Enter for 50 cycles: exactly one transition.
    trans = 0;
    prev_st = state_code;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 8'd9, 2'd0, 1'b0, 8'd0, 1'b0);
      if (state_code != prev_st) trans++;
      prev_st = state_code;
    end
    check("hold_transitions", 32'(trans), 32'd1);
    check("hold_state", 32'(state_code), 32'd1);
    check("hold_a", 32'(alu_a), 32'd9);
    idle(8'd0);

    // Divide by zero: ALU flags error.
    step(1'b0, 1'b1, 8'd0, 2'd3, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 8'd0, 2'd3, 1'b0, 8'd0, 1'b0);
    check("div_op_disp", 32'(display_value), 32'd3);
    step(1'b0, 1'b1, 8'd0, 2'd3, 1'b0, 8'd0, 1'b0);
    check("div_busy", 32'(state_code), 32'd3);
    check("div_op", 32'(alu_op), 32'd3);
    check("div_b", 32'(alu_b), 32'd0);
    step(1'b0, 1'b0, 8'd0, 2'd3, 1'b1, 8'd0, 1'b1);
    check("div_err_state", 32'(state_code), 32'd5);
    check("div_err_flag", 32'(error), 32'd1);
    check("div_err_disp", 32'(display_value), 32'hFF);
    step(1'b0, 1'b1, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0);
    check("err_ent_ignored", 32'(state_code), 32'd5);
    idle(8'd0);
    step(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0);
    check("err_clr_state", 32'(state_code), 32'd0);
    check("err_clr_flag", 32'(error), 32'd0);
    check("err_clr_op", 32'(alu_op), 32'd0);
    idle(8'd0);

    // Timeout: no done ever, ERROR 15 cycles after BUSY entry.
    launch(8'd1, 8'd2, 2'd0);
    check("to_busy", 32'(state_code), 32'd3);
    n = 0;
    while (n < 40 && state_code != 3'd5) begin
      idle(8'd0);
      n++;
    end
    check("to_cycles", 32'(n), 32'd15);
    check("to_error", 32'(error), 32'd1);
    step(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0);
    idle(8'd0);

    // Clear mid-BUSY, then a late done is discarded.
    launch(8'd4, 8'd6, 2'd2);
    check("mid_busy", 32'(state_code), 32'd3);
    idle(8'd0);
    starts = 0;
    step(1'b1, 1'b0, 8'd0, 2'd0, 1'b0, 8'd0, 1'b0);
    check("mid_clr_state", 32'(state_code), 32'd0);
    check("mid_clr_a", 32'(alu_a), 32'd0);
    if (alu_start) starts++;
    idle(8'h42);
    if (alu_start) starts++;
    idle(8'h42);
    if (alu_start) starts++;
    step(1'b0, 1'b0, 8'h42, 2'd0, 1'b1, 8'h77, 1'b0);
    if (alu_start) starts++;
    check("late_done_state", 32'(state_code), 32'd0);
    check("late_done_disp", 32'(display_value), 32'h42);
    check("mid_clr_no_start", 32'(starts), 32'd0);
    idle(8'h42);

    // Clear and Enter rising together in ENTER_B.
    step(1'b0, 1'b1, 8'd7, 2'd0, 1'b0, 8'd0, 1'b0);
    check("both_pre_state", 32'(state_code), 32'd1);
    idle(8'd7);
    step(1'b1, 1'b1, 8'd7, 2'd0, 1'b0, 8'd0, 1'b0);
    check("both_state", 32'(state_code), 32'd0);
    check("both_b", 32'(alu_b), 32'd0);
    check("both_a", 32'(alu_a), 32'd0);
    idle(8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calculator_ctrl.md
Name: calculator_ctrl

Overview:
- Sequencing FSM for the calculator, sitting between the button input stage (debounced, synchronized levels) and the arithmetic unit.
- Edge-detects Enter and Clear, then latches operand A, operand B and the opcode from the switches.
- Launches the ALU with a one-cycle start pulse, waits for its done handshake under a timeout, and holds the result or an error on the display.

Parameters:
- WIDTH, 8, operand and result width in bits.
- TIMEOUT, 1023, maximum cycles spent in BUSY waiting for alu_done before forcing ERROR.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- button_clr  in  1  debounced, synced Clear level.
- button_ent  in  1  debounced, synced Enter level.
- switches  in  WIDTH  operand entry value.
- op_sel  in  2  opcode: 0 add, 1 sub, 2 mul, 3 div.
- alu_start  out  1  single-cycle launch pulse.
- alu_a  out  WIDTH  latched operand A.
- alu_b  out  WIDTH  latched operand B.
- alu_op  out  2  latched opcode.
- alu_done  in  1  single-cycle completion pulse from the ALU.
- alu_result  in  WIDTH  ALU result, valid when alu_done is high.
- alu_err  in  1  ALU error flag (divide by zero or overflow), valid with alu_done.
- display_value  out  WIDTH  value to show on the display.
- state_code  out  3  encoded current state, for LEDs.
- error  out  1  high while in ERROR.

Behaviour:
- Edge detection
  - Registered previous level per button; an event is a rising edge (level=1, prev=0).
  - A held button produces exactly one event.
  - Both events in the same cycle: Clear wins and Enter is dropped.
- States: ENTER_A, ENTER_B, ENTER_OP, BUSY, RESULT, ERROR.
- Reset
  - State = ENTER_A.
  - alu_a, alu_b, display_value = 0; alu_op = 0; alu_start = 0; error = 0.
  - Timeout counter = 0; edge registers = 0.
- ENTER_A: display_value follows switches combinationally. On Enter: alu_a <= switches, go to ENTER_B.
- ENTER_B: display_value follows switches. On Enter: alu_b <= switches, go to ENTER_OP.
- ENTER_OP: display_value = zero-extended op_sel. On Enter: alu_op <= op_sel, assert alu_start for exactly the next cycle, go to BUSY, clear the timeout counter.
- BUSY
  - Enter is ignored. Counter increments each cycle.
  - alu_done with alu_err=0: latch result into display_value, go to RESULT.
  - alu_done with alu_err=1: go to ERROR.
  - Counter reaching TIMEOUT with no done: go to ERROR.
  - alu_done wins if it arrives in the same cycle as the timeout.
  - alu_done outside BUSY is ignored.
  - alu_a, alu_b and alu_op stay stable for the whole of BUSY.
- RESULT: display_value holds. On Enter: go to ENTER_A.
- ERROR: error=1, display_value = all ones. Enter is ignored; only Clear leaves.
- Clear from any state, including mid-BUSY
  - Go to ENTER_A next cycle; zero alu_a, alu_b and alu_op.
  - No alu_start is issued; a late alu_done is discarded.
- Latency: Enter edge to state change = 1 cycle after the edge-detect register; Enter in ENTER_OP to alu_start = 1 cycle.
- state_code encoding: ENTER_A=0, ENTER_B=1, ENTER_OP=2, BUSY=3, RESULT=4, ERROR=5.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: Enter in RESULT performs alu_a <= the held result and goes to ENTER_B, so results chain into the next operation.
- Undefined: Enter in RESULT goes to ENTER_A and alu_a is unchanged until the next entry.
- ERROR behaviour is identical in both builds.

Decomposition:
- Package calculator_pkg: enum state_t (3-bit, values above), enum op_t (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
- Sub-module edge_detect (clk, reset, level, rise), instanced once per button.
- Timeout counter and FSM live in calculator_ctrl.

Test Plan:
- Enter 5, Enter 3, op=0 Enter; stub ALU returns done+8 two cycles after start -> alu_start high exactly 1 cycle; alu_a=5, alu_b=3, alu_op=0; RESULT with display_value=8.
- Hold button_ent high for 50 cycles in ENTER_A -> exactly one transition to ENTER_B.
- op=3 with alu_b=0; stub returns alu_err=1 -> ERROR, error=1, display_value=0xFF (WIDTH=8); Enter ignored; Clear -> ENTER_A, error=0.
- Stub never returns done (TIMEOUT=15) -> ERROR entered 15 cycles after BUSY entry.
- Clear mid-BUSY, then stub alu_done 3 cycles later -> state stays ENTER_A; display_value follows switches.
- Clear and Enter rising in the same cycle in ENTER_B -> ENTER_A. With CALC_CHAIN_EN defined, Enter in RESULT=8 -> ENTER_B with alu_a=8.
